// File: rtl/seq_detector_moore_if.sv
// Serial pattern detector bus.
// Bundles the per-bit control/data inputs and the match outputs so the
// detector and its driver share one connection point.
//   en        : accept A on this clock edge
//   A         : serial data bit
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   load      : capture pat_in as the new pattern
//   pat_in    : runtime pattern, first-received bit in the MSB
//   clr_cnt   : synchronous clear of match_cnt
//   Y         : Moore match flag
//   match_cnt : saturating count of matches
// Modports: master drives the inputs and observes the results; slave is
// the detector.
interface seq_detector_moore_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             A;
  logic             overlap;
  logic             load;
  logic [N-1:0]     pat_in;
  logic             clr_cnt;
  logic             Y;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, A, overlap, load, pat_in, clr_cnt,
    input  Y, match_cnt
  );

  modport slave (
    input  en, A, overlap, load, pat_in, clr_cnt,
    output Y, match_cnt
  );
endinterface

// File: rtl/seq_detector_moore.sv
// Moore serial sequence detector with runtime-loadable pattern,
// overlap/non-overlap selection and a saturating match counter.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_detector_moore_if slave (en, A, overlap, load, pat_in,
//           clr_cnt in; Y, match_cnt out)
// Y is decoded only from registered state (full history window equal to
// the pattern), so it never depends combinationally on any input.
module seq_detector_moore #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b0101,
  parameter int           CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_detector_moore_if.slave bus
);

  localparam int             FW     = $clog2(N + 1);
  localparam logic [FW-1:0]  F_FULL = FW'(N);

  logic [N-1:0]     pat_p0,  pat_nx;
  logic [N-1:0]     hist_p0, hist_nx;
  logic [FW-1:0]    fill_p0, fill_nx;
  logic [CNT_W-1:0] cnt_p0,  cnt_nx;
  logic             y;
  logic             match_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  assign y = (fill_p0 == F_FULL) && (hist_p0 == pat_p0);

  always_comb begin
    pat_nx   = pat_p0;
    hist_nx  = hist_p0;
    fill_nx  = fill_p0;
    cnt_nx   = cnt_p0;
    match_nx = 1'b0;

    if (bus.load) begin
      pat_nx  = bus.pat_in;
      hist_nx = '0;
      fill_nx = '0;
    end else if (bus.en) begin
      hist_nx = {hist_p0[N-2:0], bus.A};
      // Non-overlap: after a match the incoming bit opens a fresh window,
      // so none of the matched bits are reused.
      if (!bus.overlap && y)
        fill_nx = FW'(1);
      else if (fill_p0 != F_FULL)
        fill_nx = fill_p0 + FW'(1);
      match_nx = (fill_nx == F_FULL) && (hist_nx == pat_p0);
    end

    // Clear wins over a coincident match.
    if (bus.clr_cnt)
      cnt_nx = '0;
    else if (match_nx)
      cnt_nx = sat_inc(cnt_p0);
  end

  // ---- stage 0: detector state registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_p0  <= PATTERN;
      hist_p0 <= '0;
      fill_p0 <= '0;
      cnt_p0  <= '0;
    end else begin
      pat_p0  <= pat_nx;
      hist_p0 <= hist_nx;
      fill_p0 <= fill_nx;
      cnt_p0  <= cnt_nx;
    end
  end

  assign bus.Y         = y;
  assign bus.match_cnt = cnt_p0;

endmodule

// File: tb/tb_seq_detector_moore.sv
module tb_seq_detector_moore;

  logic       clk;
  logic       reset;
  logic       en;
  logic       A;
  logic       overlap;
  logic       load;
  logic [3:0] pat_in;
  logic       clr_cnt;

  int tests;
  int fails;

  seq_detector_moore_if #(.N(4), .CNT_W(8)) bus  ();
  seq_detector_moore_if #(.N(4), .CNT_W(2)) bus2 ();

  assign bus.en       = en;
  assign bus.A        = A;
  assign bus.overlap  = overlap;
  assign bus.load     = load;
  assign bus.pat_in   = pat_in;
  assign bus.clr_cnt  = clr_cnt;
  assign bus2.en      = en;
  assign bus2.A       = A;
  assign bus2.overlap = overlap;
  assign bus2.load    = load;
  assign bus2.pat_in  = pat_in;
  assign bus2.clr_cnt = clr_cnt;

  seq_detector_moore #(.N(4), .PATTERN(4'b0101), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_detector_moore #(.N(4), .PATTERN(4'b0101), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are
  // sampled at that same point, i.e. well away from the active edge.
  task automatic bit_in(input logic a);
    A  = a;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    A  = 1'b0;
  endtask

  task automatic restart(input logic [3:0] pat);
    load    = 1'b1;
    clr_cnt = 1'b1;
    pat_in  = pat;
    @(posedge clk);
    #1;
    load    = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.Y !== 1'b0) begin
      fails++; $display("FAIL reset_y: got %b want 0", bus.Y);
    end
    tests++;
    if (bus.match_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d want 0", bus.match_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.Y !== 1'b0) begin
      fails++; $display("FAIL release_y: got %b want 0", bus.Y);
    end
  endtask

  task automatic test_overlap;
    logic [5:0] bits;
    logic [5:0] yexp;
    bits = 6'b010101;
    yexp = 6'b000101;
    restart(4'b0101);
    tests++;
    if (bus.match_cnt !== 8'd0 || bus.Y !== 1'b0) begin
      fails++; $display("FAIL load_clr: got cnt %0d y %b want 0 0", bus.match_cnt, bus.Y);
    end
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit_in(bits[5-i]);
      tests++;
      if (bus.Y !== yexp[5-i]) begin
        fails++; $display("FAIL overlap_y bit%0d: got %b want %b", i + 1, bus.Y, yexp[5-i]);
      end
    end
    tests++;
    if (bus.match_cnt !== 8'd2) begin
      fails++; $display("FAIL overlap_cnt: got %0d want 2", bus.match_cnt);
    end
  endtask

  task automatic test_nonoverlap;
    logic [7:0] bits;
    logic [7:0] yexp;
    bits = 8'b01010101;
    yexp = 8'b00010001;
    restart(4'b0101);
    overlap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_in(bits[7-i]);
      tests++;
      if (bus.Y !== yexp[7-i]) begin
        fails++; $display("FAIL nonoverlap_y bit%0d: got %b want %b", i + 1, bus.Y, yexp[7-i]);
      end
      if (i == 5) begin
        tests++;
        if (bus.match_cnt !== 8'd1) begin
          fails++; $display("FAIL nonoverlap_cnt6: got %0d want 1", bus.match_cnt);
        end
      end
    end
    tests++;
    if (bus.match_cnt !== 8'd2) begin
      fails++; $display("FAIL nonoverlap_cnt: got %0d want 2", bus.match_cnt);
    end
  endtask

  task automatic test_enable;
    restart(4'b0101);
    overlap = 1'b1;
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      A  = ~A;
      @(posedge clk);
      #1;
      tests++;
      if (bus.Y !== 1'b0) begin
        fails++; $display("FAIL enable_gap_y cyc%0d: got %b want 0", i, bus.Y);
      end
    end
    bit_in(1'b1);
    tests++;
    if (bus.Y !== 1'b1) begin
      fails++; $display("FAIL enable_y: got %b want 1", bus.Y);
    end
    for (int i = 0; i < 3; i++) begin
      A = ~A;
      @(posedge clk);
      #1;
      tests++;
      if (bus.Y !== 1'b1 || bus.match_cnt !== 8'd1) begin
        fails++; $display("FAIL enable_hold cyc%0d: got y %b cnt %0d want 1 1", i, bus.Y, bus.match_cnt);
      end
    end
  endtask

  task automatic test_load;
    logic [7:0] bits;
    logic [7:0] yexp;
    bits = 8'b11000101;
    yexp = 8'b00010000;
    restart(4'b1100);
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_in(bits[7-i]);
      tests++;
      if (bus.Y !== yexp[7-i]) begin
        fails++; $display("FAIL load_y bit%0d: got %b want %b", i + 1, bus.Y, yexp[7-i]);
      end
    end
    tests++;
    if (bus.match_cnt !== 8'd1) begin
      fails++; $display("FAIL load_cnt: got %0d want 1", bus.match_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [11:0] bits;
    bits = 12'b010101010101;
    restart(4'b0101);
    overlap = 1'b1;
    for (int i = 0; i < 12; i++) bit_in(bits[11-i]);
    tests++;
    if (bus2.match_cnt !== 2'd3) begin
      fails++; $display("FAIL sat_cnt2: got %0d want 3", bus2.match_cnt);
    end
    tests++;
    if (bus.match_cnt !== 8'd5) begin
      fails++; $display("FAIL sat_cnt8: got %0d want 5", bus.match_cnt);
    end
    bit_in(1'b0);
    clr_cnt = 1'b1;
    bit_in(1'b1);
    clr_cnt = 1'b0;
    tests++;
    if (bus.Y !== 1'b1 || bus.match_cnt !== 8'd0 || bus2.match_cnt !== 2'd0) begin
      fails++; $display("FAIL clr_on_match: got y %b cnt %0d cnt2 %0d want 1 0 0",
                        bus.Y, bus.match_cnt, bus2.match_cnt);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] bits;
    logic [3:0] yexp;
    restart(4'b1100);
    overlap = 1'b1;
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b0);
    tests++;
    if (bus.Y !== 1'b1 || bus.match_cnt !== 8'd1) begin
      fails++; $display("FAIL prereset: got y %b cnt %0d want 1 1", bus.Y, bus.match_cnt);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (bus.Y !== 1'b0 || bus.match_cnt !== 8'd0) begin
      fails++; $display("FAIL async_reset: got y %b cnt %0d want 0 0", bus.Y, bus.match_cnt);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (bus.Y !== 1'b0 || bus.match_cnt !== 8'd0) begin
      fails++; $display("FAIL midpat_reset: got y %b cnt %0d want 0 0", bus.Y, bus.match_cnt);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    bit_in(1'b1);
    tests++;
    if (bus.Y !== 1'b0) begin
      fails++; $display("FAIL after_reset_single: got %b want 0", bus.Y);
    end
    bits = 4'b0101;
    yexp = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[3-i]);
      tests++;
      if (bus.Y !== yexp[3-i]) begin
        fails++; $display("FAIL after_reset_y bit%0d: got %b want %b", i + 1, bus.Y, yexp[3-i]);
      end
    end
    tests++;
    if (bus.match_cnt !== 8'd1) begin
      fails++; $display("FAIL after_reset_cnt: got %0d want 1", bus.match_cnt);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b0;
    en      = 1'b0;
    A       = 1'b0;
    overlap = 1'b1;
    load    = 1'b0;
    pat_in  = 4'b0000;
    clr_cnt = 1'b0;
    #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_enable();
    test_load();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detector_moore.md
SEQ_DETECTOR_MOORE -- requirements
Module: seq_detector_moore

Interface
REQ-001 SHALL provide parameter N, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b0101, meaning the pattern loaded at reset, first-received bit in the MSB.
REQ-003 SHALL provide parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset: low forces reset state immediately, independent of clk.
REQ-006 SHALL have port en, input, 1, meaning A is sampled on this edge.
REQ-007 SHALL have port A, input, 1, meaning the serial data bit.
REQ-008 SHALL have port overlap, input, 1, meaning 1 selects overlapping detection and 0 selects non-overlapping detection.
REQ-009 SHALL have port load, input, 1, meaning capture pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, N, meaning the runtime pattern, first-received bit in the MSB.
REQ-011 SHALL have port clr_cnt, input, 1, meaning synchronous clear of match_cnt.
REQ-012 SHALL have port Y, output, 1, meaning the Moore match flag.
REQ-013 SHALL have port match_cnt, output, CNT_W, meaning the saturating count of matches.

Function
REQ-014 SHALL hold internal state: pattern register P[N-1:0], history shift register H[N-1:0], and fill counter F (0..N).
REQ-015 SHALL derive Y purely from registered state, Moore style: Y = (F == N) and (H == P); Y SHALL NOT depend combinationally on any input.
REQ-016 SHALL, on an edge with load=1: set P <= pat_in, H <= 0 and F <= 0, and ignore en/A on that edge.
REQ-017 SHALL, on an edge with load=0 and en=1: shift H <= {H[N-2:0], A}.
REQ-018 SHALL, on the same load=0/en=1 edge, update F as follows.
- Default: F <= min(F+1, N).
- Exception: if overlap=0 and Y=1 before the edge, F <= 1, so the new bit starts a fresh window and matched bits are not reused.
REQ-019 SHALL, on an edge with load=0 and en=0, hold P, H, F, and therefore Y.
REQ-020 SHALL assert Y in the cycle after the edge that samples the final pattern bit (latency 1 clock), and keep Y high while en=0.
REQ-021 SHALL, in overlap mode, assert Y on consecutive accepted bits whenever each N-bit window matches (e.g. an all-ones pattern with a constant 1 stream).
REQ-022 SHALL increment match_cnt on each edge where load=0, en=1, and the next state is a match (F_next == N and H_next == P).
REQ-023 SHALL saturate match_cnt at 2^CNT_W-1 with no wrap.
REQ-024 SHALL give clr_cnt priority over increment: on an edge with clr_cnt=1, match_cnt <= 0 even if a match occurs on that edge.
REQ-025 SHALL allow load and clr_cnt on the same edge, with both taking effect.
REQ-026 SHALL read overlap on every accepted edge; a change to overlap takes effect on the next accepted bit.

Reset
REQ-027 SHALL, while reset=0: set P <= PATTERN, H <= 0, F <= 0, match_cnt <= 0 and Y = 0, asynchronously.
REQ-028 SHALL, when reset asserts mid-pattern, discard the partial match; after release, detection restarts with F=0.
REQ-029 SHALL be release-safe: the first rising edge after reset deasserts behaves as a normal edge.

Verification
REQ-030 SHALL cover overlap mode: N=4, P=0101, overlap=1, en=1, A=0,1,0,1,0,1 -> Y=1 the cycle after bits 4 and 6, Y=0 otherwise, match_cnt=2.
REQ-031 SHALL cover non-overlap mode: same stream with overlap=0 -> Y=1 only after bit 4, match_cnt=1; continuing with A=0,1 -> Y=1 again, match_cnt=2.
REQ-032 SHALL cover enable gating: send 0,1,0, hold en=0 for 5 cycles with A toggling, then send 1 -> Y=1 exactly one cycle after the final accepted 1, match_cnt=1.
REQ-033 SHALL cover runtime load: load=1 with pat_in=1100, then A=1,1,0,0 -> Y=1 after bit 4; stream 0101 afterwards -> Y stays 0.
REQ-034 SHALL cover saturation and clear: CNT_W=2 with 5 matches -> match_cnt=3; clr_cnt=1 on a match edge -> match_cnt=0.
REQ-035 SHALL cover asynchronous reset: reset=0 asserted between clock edges after 0,1,0 -> Y=0, match_cnt=0 immediately; after release, a single 1 gives Y=0, and a full 0101 gives Y=1.
